// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter
// Shares one single-ported memory between the instruction-fetch port and the
// load/store port. One access is in flight at a time. The data port has
// priority, and a saturating starvation counter forces a fetch grant after
// STARVE_MAX consecutive data grants taken while a fetch was waiting.
// mem_rdata is expected valid in the response cycle, MEM_LAT cycles after the
// mem_en cycle. It is forwarded to the owner in that cycle and captured so
// that the rdata outputs hold it until the owner's next response.
module unified_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  // The wait counter holds at most MEM_LAT-1; the starve counter at most STARVE_MAX.
  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int SC_W  = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic              owner;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [CNT_W-1:0]  wait_cnt;
  logic [SC_W-1:0]   starve_cnt;
  logic [DATA_W-1:0] if_hold;
  logic [DATA_W-1:0] d_hold;

  logic arb;
  logic any_req;
  logic starved;
  logic pick_d;
  logic issue;
  logic resp;

  // Saturating increment for the starvation counter.
  function automatic logic [SC_W-1:0] sat_inc(input logic [SC_W-1:0] v);
    return (v == SC_W'(STARVE_MAX)) ? v : v + SC_W'(1);
  endfunction

  // Arbitration happens only in IDLE and RESP, so RESP overlaps the next pick.
  assign arb     = (state == IDLE) || (state == RESP);
  assign any_req = if_req | d_req;
  assign starved = if_req && (starve_cnt == SC_W'(STARVE_MAX));
  assign pick_d  = d_req && !starved;
  assign issue   = (state == ISSUE);
  assign resp    = (state == RESP);

  // Next-state selection for the access sequencer.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ISSUE;
      ISSUE:   state_nxt = (MEM_LAT > 1) ? WAIT : RESP;
      WAIT:    if (wait_cnt == CNT_W'(1)) state_nxt = RESP;
      RESP:    state_nxt = any_req ? ISSUE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, winner capture and latency countdown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      owner    <= OWN_IF;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wait_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (arb && any_req) begin
        owner   <= pick_d ? OWN_D : OWN_IF;
        addr_q  <= pick_d ? d_addr : if_addr;
        we_q    <= pick_d & d_we;
        wdata_q <= pick_d ? d_wdata : '0;
      end
      if (issue) begin
        wait_cnt <= CNT_W'(MEM_LAT - 1);
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt - CNT_W'(1);
      end
    end
  end

  // Starvation counter: counts data wins while a fetch is pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!if_req) begin
      starve_cnt <= '0;
    end else if (arb && any_req) begin
      starve_cnt <= pick_d ? sat_inc(starve_cnt) : '0;
    end
  end

  // Capture the response word so rdata holds between rvalid pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_hold <= '0;
      d_hold  <= '0;
    end else if (resp) begin
      if (owner == OWN_D) begin
        d_hold <= we_q ? '0 : mem_rdata;
      end else begin
        if_hold <= mem_rdata;
      end
    end
  end

  assign if_gnt    = issue & (owner == OWN_IF);
  assign d_gnt     = issue & (owner == OWN_D);
  assign mem_en    = issue;
  assign mem_we    = issue & we_q;
  assign mem_addr  = issue ? addr_q : '0;
  assign mem_wdata = (issue & we_q) ? wdata_q : '0;

  assign if_rvalid = resp & (owner == OWN_IF);
  assign d_rvalid  = resp & (owner == OWN_D);
  assign if_rdata  = if_rvalid ? mem_rdata : if_hold;
  assign d_rdata   = d_rvalid ? (we_q ? '0 : mem_rdata) : d_hold;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: two instances (MEM_LAT=1 and MEM_LAT=3), each
// with a behavioural memory, per-port transaction queues and a monitor.
module tb_unified_mem_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SMAX = 4;

  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } txn_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] init_word(input int i);
    if (i == 4) return 32'h0050_0093;
    return 32'h1300_0000 ^ (32'(i) * 32'h0001_0203);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int LAT = (g == 0) ? 1 : 3;

    logic          rst_n;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt, if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          d_req, d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt, d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [133:0]  outs;

    bit done = 1'b0;
    int cyc  = 0;

    txn_t if_iss[$], d_iss[$], if_rsp[$], d_rsp[$];
    int   if_t[$], d_t[$];
    bit   glog[$];
    int   last_if_gnt = -1, last_if_rv = -1, last_d_gnt = -1, last_d_rv = -1;
    logic [DW-1:0] last_if_data = '0, last_d_data = '0;

    logic [DW-1:0] mem [256];
    logic [DW-1:0] ref_mem [256];
    logic [DW-1:0] pipe [LAT];

    assign outs = {if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
                   mem_en, mem_we, mem_addr, mem_wdata};

    unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
    );

    initial begin
      for (int i = 0; i < 256; i++) begin
        mem[i]     = init_word(i);
        ref_mem[i] = init_word(i);
      end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Memory: write at the mem_en edge; read word appears LAT cycles after mem_en, garbage otherwise.
    always @(posedge clk) begin
      if (mem_en && mem_we) mem[mem_addr[9:2]] <= mem_wdata;
      pipe[0] <= (mem_en && !mem_we) ? mem[mem_addr[9:2]] : $urandom;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_rdata = pipe[LAT-1];

    // Monitor: pairs grants with issued requests, responses with grants, checks arbitration rules.
    bit p_if = 1'b0, p_d = 1'b0;
    int scnt = 0;
    always @(negedge clk) begin
      txn_t t;
      int   tg;
      if (!rst_n) begin
        if_iss.delete(); d_iss.delete(); if_rsp.delete(); d_rsp.delete();
        if_t.delete(); d_t.delete();
        scnt = 0; p_if = 1'b0; p_d = 1'b0;
        last_if_data = '0; last_d_data = '0;
      end else begin
        if (if_gnt || d_gnt || mem_en) begin
          chk(!(if_gnt && d_gnt), "gnt_exclusive", 64'({if_gnt, d_gnt}), 64'(1));
          chk(mem_en == (if_gnt | d_gnt), "mem_en_vs_gnt", 64'(mem_en), 64'(if_gnt | d_gnt));
        end
        if (mem_we) chk(d_gnt && mem_en, "mem_we_qualified", 64'({d_gnt, mem_en}), 64'(3));
        if (if_rvalid || d_rvalid)
          chk(!(if_rvalid && d_rvalid), "rvalid_exclusive", 64'({if_rvalid, d_rvalid}), 64'(1));

        if (if_gnt) begin
          chk(if_iss.size() > 0, "if_gnt_expected", 64'(if_iss.size()), 64'(1));
          if (if_iss.size() > 0) begin
            t = if_iss.pop_front();
            chk(mem_addr == t.addr, "if_mem_addr", 64'(mem_addr), 64'(t.addr));
            chk(!mem_we, "if_mem_we", 64'(mem_we), 64'(0));
            if_rsp.push_back(t); if_t.push_back(cyc);
          end
          if (p_d) chk(scnt == SMAX, "fetch_over_data_only_when_starved", 64'(scnt), 64'(SMAX));
          scnt = 0; glog.push_back(1'b0); last_if_gnt = cyc;
        end else if (d_gnt) begin
          chk(d_iss.size() > 0, "d_gnt_expected", 64'(d_iss.size()), 64'(1));
          if (d_iss.size() > 0) begin
            t = d_iss.pop_front();
            chk(mem_addr == t.addr, "d_mem_addr", 64'(mem_addr), 64'(t.addr));
            chk(mem_we == t.we, "d_mem_we", 64'(mem_we), 64'(t.we));
            if (t.we) chk(mem_wdata == t.wdata, "d_mem_wdata", 64'(mem_wdata), 64'(t.wdata));
            d_rsp.push_back(t); d_t.push_back(cyc);
          end
          if (p_if) begin
            chk(scnt < SMAX, "fetch_starved", 64'(scnt), 64'(SMAX - 1));
            if (scnt < SMAX) scnt++;
          end else begin
            scnt = 0;
          end
          glog.push_back(1'b1); last_d_gnt = cyc;
        end else if (!p_if) begin
          scnt = 0;
        end

        if (if_rvalid) begin
          chk(if_rsp.size() > 0, "if_rvalid_expected", 64'(if_rsp.size()), 64'(1));
          if (if_rsp.size() > 0) begin
            t = if_rsp.pop_front(); tg = if_t.pop_front();
            chk(if_rdata == t.rdata, "if_rdata", 64'(if_rdata), 64'(t.rdata));
            chk(cyc - tg == LAT, "if_latency", 64'(cyc - tg), 64'(LAT));
          end
          last_if_data = if_rdata; last_if_rv = cyc;
        end else begin
          chk(if_rdata == last_if_data, "if_rdata_hold", 64'(if_rdata), 64'(last_if_data));
        end
        if (d_rvalid) begin
          chk(d_rsp.size() > 0, "d_rvalid_expected", 64'(d_rsp.size()), 64'(1));
          if (d_rsp.size() > 0) begin
            t = d_rsp.pop_front(); tg = d_t.pop_front();
            chk(d_rdata == t.rdata, "d_rdata", 64'(d_rdata), 64'(t.rdata));
            chk(cyc - tg == LAT, "d_latency", 64'(cyc - tg), 64'(LAT));
          end
          last_d_data = d_rdata; last_d_rv = cyc;
        end else begin
          chk(d_rdata == last_d_data, "d_rdata_hold", 64'(d_rdata), 64'(last_d_data));
        end
        p_if = if_req; p_d = d_req;
      end
    end

    task automatic fetch(input logic [AW-1:0] a);
      txn_t t;
      bit   got = 1'b0;
      t.addr = a; t.we = 1'b0; t.wdata = '0; t.rdata = ref_mem[a[9:2]];
      if_iss.push_back(t);
      if_addr = a; if_req = 1'b1;
      for (int n = 0; n < 200; n++) begin
        @(negedge clk);
        if (if_gnt) begin got = 1'b1; break; end
      end
      chk(got, "if_gnt_timeout", 64'(got), 64'(1));
      @(posedge clk); #1;
      if_req = 1'b0; if_addr = $urandom;
    endtask

    task automatic dacc(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
      txn_t t;
      bit   got = 1'b0;
      t.addr = a; t.we = we; t.wdata = wd;
      t.rdata = we ? '0 : ref_mem[a[9:2]];
      if (we) ref_mem[a[9:2]] = wd;
      d_iss.push_back(t);
      d_we = we; d_addr = a; d_wdata = wd; d_req = 1'b1;
      for (int n = 0; n < 200; n++) begin
        @(negedge clk);
        if (d_gnt) begin got = 1'b1; break; end
      end
      chk(got, "d_gnt_timeout", 64'(got), 64'(1));
      @(posedge clk); #1;
      d_req = 1'b0; d_we = $urandom_range(0, 1); d_addr = $urandom; d_wdata = $urandom;
    endtask

    task automatic drain();
      bit ok = 1'b0;
      for (int n = 0; n < 400; n++) begin
        @(negedge clk); #1;
        if (if_iss.size() == 0 && d_iss.size() == 0 && if_rsp.size() == 0 && d_rsp.size() == 0) begin
          ok = 1'b1; break;
        end
      end
      chk(ok, "drain_timeout", 64'(ok), 64'(1));
      @(posedge clk); #1;
    endtask

    initial begin
      int t0, g0, seen;
      rst_n = 1'b0; if_req = 1'b0; if_addr = '0;
      d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      chk(outs == '0, "reset_outputs", 64'($countones(outs)), 64'(0));
      rst_n = 1'b1;
      @(posedge clk); #1;

      if (LAT == 1) begin
        t0 = cyc;
        fetch(32'h10);
        drain();
        chk(last_if_gnt == t0 + 1, "t1_if_gnt_cycle", 64'(last_if_gnt - t0), 64'(1));
        chk(last_if_rv == t0 + 2, "t1_if_rvalid_cycle", 64'(last_if_rv - t0), 64'(2));
        chk(last_if_data == 32'h0050_0093, "t1_if_rdata", 64'(last_if_data), 64'(32'h0050_0093));

        t0 = cyc;
        fork
          fetch(32'h20);
          dacc(1'b0, 32'h200, '0);
        join
        drain();
        chk(last_d_gnt == t0 + 1, "t2_d_gnt_cycle", 64'(last_d_gnt - t0), 64'(1));
        chk(last_d_rv == t0 + 2, "t2_d_rvalid_cycle", 64'(last_d_rv - t0), 64'(2));
        chk(last_if_gnt == t0 + 3, "t2_if_gnt_cycle", 64'(last_if_gnt - t0), 64'(3));
        chk(last_if_rv == t0 + 4, "t2_if_rvalid_cycle", 64'(last_if_rv - t0), 64'(4));

        dacc(1'b1, 32'h204, 32'hDEAD_BEEF);
        dacc(1'b0, 32'h204, '0);
        drain();
        chk(mem[8'h81] == 32'hDEAD_BEEF, "t3_mem_content", 64'(mem[8'h81]), 64'(32'hDEAD_BEEF));
        chk(last_d_data == 32'hDEAD_BEEF, "t3_load_back", 64'(last_d_data), 64'(32'hDEAD_BEEF));

        g0 = glog.size();
        fork
          repeat (10) fetch(32'(4 * $urandom_range(0, 63)));
          repeat (40) dacc(1'b0, 32'h200 + 32'(4 * $urandom_range(0, 63)), '0);
        join
        drain();
        for (int i = 0; i < 15; i++)
          chk(glog[g0 + i] == (i % 5 != 4), "t4_grant_pattern", 64'(glog[g0 + i]), 64'(i % 5 != 4));
      end else begin
        t0 = cyc;
        dacc(1'b0, 32'h208, '0);
        drain();
        chk(last_d_gnt == t0 + 1, "t6_d_gnt_cycle", 64'(last_d_gnt - t0), 64'(1));
        chk(last_d_rv == t0 + 4, "t6_d_rvalid_cycle", 64'(last_d_rv - t0), 64'(4));
        chk(!d_rvalid, "t6_rvalid_width", 64'(d_rvalid), 64'(0));

        dacc(1'b0, 32'h20C, '0);
        rst_n = 1'b0;
        #1;
        chk(outs == '0, "t5_outputs_in_reset", 64'($countones(outs)), 64'(0));
        @(negedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (8) begin
          @(negedge clk);
          if (d_rvalid || mem_en) seen++;
        end
        chk(seen == 0, "t5_quiet_after_reset", 64'(seen), 64'(0));
        @(posedge clk); #1;

        seen = 0;
        fork
          dacc(1'b0, 32'h210, '0);
          begin
            @(posedge clk); #2;
            if_addr = 32'h30; if_req = 1'b1;
            @(posedge clk); #2;
            if_req = 1'b0;
            repeat (8) begin
              @(negedge clk);
              if (if_gnt) seen++;
            end
          end
        join
        drain();
        chk(seen == 0, "withdrawn_fetch_not_granted", 64'(seen), 64'(0));
      end

      fork
        repeat (25) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          fetch(32'(4 * $urandom_range(0, 63)));
        end
        repeat (30) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          dacc(1'($urandom_range(0, 1)), 32'h200 + 32'(4 * $urandom_range(0, 63)), $urandom);
        end
      join
      drain();
      done = 1'b1;
    end
  end

  initial begin
    fork
      wait (lane[0].done && lane[1].done);
      #300000;
    join_any
    disable fork;
    chk(lane[0].done && lane[1].done, "lanes_done", 64'({lane[1].done, lane[0].done}), 64'(3));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
